// File: rtl/sram_arb_pkg.sv
// Shared types and limits for the two-master sram-like bus arbiter.
// Owner tags identify which master issued each in-flight transaction.
package sram_arb_pkg;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam int unsigned MAX_OUTSTANDING_LIMIT = 4;
  localparam int unsigned COUNT_W = $clog2(MAX_OUTSTANDING_LIMIT + 1);

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_INST) ? OWN_DATA : OWN_INST;
  endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// Circular FIFO of owner tags, one entry per accepted-but-unanswered transaction.
// Pushes while full and pops while empty are dropped so count stays in range.
module arb_owner_fifo
  import sram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  owner_e             din,
  output owner_e             head,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(DEPTH);

  owner_e           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // With count==1 the write slot is always distinct from the head slot,
  // so a simultaneous push and pop never overwrites the entry being read.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + COUNT_W'(1);
        2'b01:   count <= count - COUNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Merges the inst and data sram-like masters onto one sram-like slave port,
// tracking in-flight owners in issue order to route data_ok/rdata back.
//
// state      | meaning
// ARB_OPEN   | no grant held; winner picked from live requests each cycle
// ARB_LOCKED | request shown without addr_ok; grant frozen on locked_owner
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned DATA_PRIORITY   = 1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok
);

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX_OUTSTANDING);

  arb_state_e         state;
  owner_e             locked_owner;
  owner_e             rr_ptr;
  owner_e             winner;
  owner_e             head;
  logic               winner_req;
  logic               accept;
  logic               pop;
  logic               full;
  logic               empty;
  logic [COUNT_W-1:0] count;
  logic               post_rst;

  always_comb begin
    winner = OWN_INST;
    if (state == ARB_LOCKED) begin
      winner = locked_owner;
    end else if (inst_req && data_req) begin
      winner = (DATA_PRIORITY != 0) ? OWN_DATA : rr_ptr;
    end else if (data_req) begin
      winner = OWN_DATA;
    end
  end

  assign winner_req = (winner == OWN_DATA) ? data_req : inst_req;

  // full comes straight from the registered count, so a same-cycle pop
  // cannot reopen the grant and bus_data_ok never reaches bus_req.
  assign bus_req   = !rst && !full && winner_req;
  assign bus_wr    = (winner == OWN_DATA) ? data_wr    : inst_wr;
  assign bus_size  = (winner == OWN_DATA) ? data_size  : inst_size;
  assign bus_addr  = (winner == OWN_DATA) ? data_addr  : inst_addr;
  assign bus_wdata = (winner == OWN_DATA) ? data_wdata : inst_wdata;

  assign accept       = bus_req && bus_addr_ok;
  assign inst_addr_ok = accept && (winner == OWN_INST);
  assign data_addr_ok = accept && (winner == OWN_DATA);

  assign pop          = !rst && bus_data_ok && !empty;
  assign inst_data_ok = pop && (head == OWN_INST);
  assign data_data_ok = pop && (head == OWN_DATA);
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  arb_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .din   (winner),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB_OPEN;
      locked_owner <= OWN_INST;
      rr_ptr       <= OWN_INST;
      post_rst     <= 1'b1;
    end else begin
      case (state)
        ARB_OPEN: begin
          if (bus_req && !bus_addr_ok) begin
            state        <= ARB_LOCKED;
            locked_owner <= winner;
          end
        end
        ARB_LOCKED: begin
          if (!bus_req || bus_addr_ok) begin
            state <= ARB_OPEN;
          end
        end
        default: state <= ARB_OPEN;
      endcase
      if (accept) begin
        rr_ptr   <= other_owner(winner);
        post_rst <= 1'b0;
      end
    end
  end

  // Until the first post-reset grant, leftover responses from before the
  // reset are expected and silently dropped; afterwards they are a slave bug.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(bus_data_ok && empty && !post_rst))
        else $error("sram_bus_arbiter: bus_data_ok with no transaction outstanding");
      assert (count <= MAX_C)
        else $error("sram_bus_arbiter: outstanding count above limit");
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: one priority instance and one round-robin instance,
// each compared every cycle against a queue-based model of the arbitration rules.
module tb_sram_bus_arbiter;
  import sram_arb_pkg::*;

  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        inst_req [2];
  logic        inst_wr [2];
  logic [1:0]  inst_size [2];
  logic [31:0] inst_addr [2];
  logic [31:0] inst_wdata [2];
  logic [31:0] inst_rdata [2];
  logic        inst_addr_ok [2];
  logic        inst_data_ok [2];
  logic        data_req [2];
  logic        data_wr [2];
  logic [1:0]  data_size [2];
  logic [31:0] data_addr [2];
  logic [31:0] data_wdata [2];
  logic [31:0] data_rdata [2];
  logic        data_addr_ok [2];
  logic        data_data_ok [2];
  logic        bus_req [2];
  logic        bus_wr [2];
  logic [1:0]  bus_size [2];
  logic [31:0] bus_addr [2];
  logic [31:0] bus_wdata [2];
  logic [31:0] bus_rdata [2];
  logic        bus_addr_ok [2];
  logic        bus_data_ok [2];

  // instance 0: data priority, instance 1: round-robin
  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_bus_arbiter #(
      .MAX_OUTSTANDING (MAXO),
      .DATA_PRIORITY   ((g == 0) ? 1 : 0)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .inst_req     (inst_req[g]),
      .inst_wr      (inst_wr[g]),
      .inst_size    (inst_size[g]),
      .inst_addr    (inst_addr[g]),
      .inst_wdata   (inst_wdata[g]),
      .inst_rdata   (inst_rdata[g]),
      .inst_addr_ok (inst_addr_ok[g]),
      .inst_data_ok (inst_data_ok[g]),
      .data_req     (data_req[g]),
      .data_wr      (data_wr[g]),
      .data_size    (data_size[g]),
      .data_addr    (data_addr[g]),
      .data_wdata   (data_wdata[g]),
      .data_rdata   (data_rdata[g]),
      .data_addr_ok (data_addr_ok[g]),
      .data_data_ok (data_data_ok[g]),
      .bus_req      (bus_req[g]),
      .bus_wr       (bus_wr[g]),
      .bus_size     (bus_size[g]),
      .bus_addr     (bus_addr[g]),
      .bus_wdata    (bus_wdata[g]),
      .bus_rdata    (bus_rdata[g]),
      .bus_addr_ok  (bus_addr_ok[g]),
      .bus_data_ok  (bus_data_ok[g])
    );
  end

  int vectors = 0;
  int miscompares = 0;

  // reference model: in-flight owners in issue order plus grant bookkeeping
  owner_e q0[$];
  owner_e q1[$];
  logic   m_locked [2];
  owner_e m_lock_own [2];
  owner_e m_rr [2];
  logic   e_acc [2];
  logic   e_pop [2];
  logic   e_breq [2];
  owner_e e_win [2];

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic owner_e qhead(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic eval();
    #1;
    for (int k = 0; k < 2; k++) begin
      int     n;
      owner_e g;
      owner_e hd;
      logic   req_g;
      logic   breq;
      logic   acc;
      logic   popv;
      n = qsize(k);
      if (m_locked[k])                   g = m_lock_own[k];
      else if (inst_req[k] && data_req[k]) g = (k == 0) ? OWN_DATA : m_rr[k];
      else if (data_req[k])              g = OWN_DATA;
      else                               g = OWN_INST;
      req_g = (g == OWN_DATA) ? data_req[k] : inst_req[k];
      breq  = !rst && (n < MAXO) && req_g;
      acc   = breq && bus_addr_ok[k];
      popv  = !rst && bus_data_ok[k] && (n > 0);
      hd    = (n > 0) ? qhead(k) : OWN_INST;
      chk($sformatf("dut%0d bus_req", k), 32'(bus_req[k]), 32'(breq));
      if (breq) begin
        chk($sformatf("dut%0d bus_addr", k), bus_addr[k], (g == OWN_DATA) ? data_addr[k] : inst_addr[k]);
        chk($sformatf("dut%0d bus_wdata", k), bus_wdata[k], (g == OWN_DATA) ? data_wdata[k] : inst_wdata[k]);
        chk($sformatf("dut%0d bus_wr", k), 32'(bus_wr[k]), 32'((g == OWN_DATA) ? data_wr[k] : inst_wr[k]));
        chk($sformatf("dut%0d bus_size", k), 32'(bus_size[k]), 32'((g == OWN_DATA) ? data_size[k] : inst_size[k]));
      end
      chk($sformatf("dut%0d inst_addr_ok", k), 32'(inst_addr_ok[k]), 32'(acc && g == OWN_INST));
      chk($sformatf("dut%0d data_addr_ok", k), 32'(data_addr_ok[k]), 32'(acc && g == OWN_DATA));
      chk($sformatf("dut%0d inst_data_ok", k), 32'(inst_data_ok[k]), 32'(popv && hd == OWN_INST));
      chk($sformatf("dut%0d data_data_ok", k), 32'(data_data_ok[k]), 32'(popv && hd == OWN_DATA));
      chk($sformatf("dut%0d inst_rdata", k), inst_rdata[k], bus_rdata[k]);
      chk($sformatf("dut%0d data_rdata", k), data_rdata[k], bus_rdata[k]);
      e_acc[k]  = acc;
      e_pop[k]  = popv;
      e_breq[k] = breq;
      e_win[k]  = g;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        if (k == 0) q0.delete(); else q1.delete();
        m_locked[k] = 1'b0;
        m_rr[k]     = OWN_INST;
      end else begin
        if (e_pop[k]) begin
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (e_acc[k]) begin
          if (k == 0) q0.push_back(e_win[k]); else q1.push_back(e_win[k]);
          m_locked[k] = 1'b0;
          m_rr[k]     = (e_win[k] == OWN_INST) ? OWN_DATA : OWN_INST;
        end else if (e_breq[k]) begin
          m_locked[k]   = 1'b1;
          m_lock_own[k] = e_win[k];
        end else begin
          m_locked[k] = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic set_inst(input logic req, input logic [31:0] addr);
    for (int k = 0; k < 2; k++) begin
      inst_req[k]   = req;
      inst_wr[k]    = 1'b0;
      inst_size[k]  = 2'd2;
      inst_addr[k]  = addr;
      inst_wdata[k] = ~addr;
    end
  endtask

  task automatic set_data(input logic req, input logic wr, input logic [31:0] addr);
    for (int k = 0; k < 2; k++) begin
      data_req[k]   = req;
      data_wr[k]    = wr;
      data_size[k]  = 2'd2;
      data_addr[k]  = addr;
      data_wdata[k] = addr ^ 32'h5a5a_5a5a;
    end
  endtask

  task automatic set_bus(input logic aok, input logic dok, input logic [31:0] rdata);
    for (int k = 0; k < 2; k++) begin
      bus_addr_ok[k] = aok;
      bus_data_ok[k] = dok;
      bus_rdata[k]   = rdata;
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_locked[k] = 1'b0; m_lock_own[k] = OWN_INST; m_rr[k] = OWN_INST;
      e_acc[k] = 1'b0; e_pop[k] = 1'b0; e_breq[k] = 1'b0; e_win[k] = OWN_INST;
    end
    rst = 1'b1;
    set_inst(1'b0, 32'h0);
    set_data(1'b0, 1'b0, 32'h0);
    set_bus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    eval(); adv();
    set_inst(1'b1, 32'h0000_0100);
    eval();
    chk("reset bus_req", 32'(bus_req[0]), 32'd0);
    chk("reset inst_addr_ok", 32'(inst_addr_ok[0]), 32'd0);
    adv();
    rst = 1'b0;

    // single inst read, answered three cycles later
    set_inst(1'b1, 32'h0000_1000); set_bus(1'b1, 1'b0, 32'h0);
    eval();
    chk("t1 inst_addr_ok", 32'(inst_addr_ok[0]), 32'd1);
    chk("t1 bus_addr", bus_addr[0], 32'h0000_1000);
    adv();
    set_inst(1'b0, 32'h0); set_bus(1'b0, 1'b0, 32'h0);
    eval(); adv();
    eval(); adv();
    set_bus(1'b0, 1'b1, 32'h1234_5678);
    eval();
    chk("t1 inst_data_ok", 32'(inst_data_ok[0]), 32'd1);
    chk("t1 inst_rdata", inst_rdata[0], 32'h1234_5678);
    chk("t1 data_data_ok", 32'(data_data_ok[0]), 32'd0);
    adv();

    // contested grant under data priority
    set_inst(1'b1, 32'h0000_2000); set_data(1'b1, 1'b0, 32'h0000_3000); set_bus(1'b1, 1'b0, 32'h0);
    eval();
    chk("t2 first bus_addr", bus_addr[0], 32'h0000_3000);
    chk("t2 data_addr_ok", 32'(data_addr_ok[0]), 32'd1);
    chk("t2 inst waits", 32'(inst_addr_ok[0]), 32'd0);
    adv();
    set_data(1'b0, 1'b0, 32'h0);
    eval();
    chk("t2 second bus_addr", bus_addr[0], 32'h0000_2000);
    chk("t2 inst_addr_ok", 32'(inst_addr_ok[0]), 32'd1);
    adv();
    set_inst(1'b0, 32'h0); set_bus(1'b0, 1'b1, 32'h0000_000a);
    eval();
    chk("t2 return data first", 32'(data_data_ok[0]), 32'd1);
    adv();
    set_bus(1'b0, 1'b1, 32'h0000_000b);
    eval();
    chk("t2 return inst second", 32'(inst_data_ok[0]), 32'd1);
    adv();
    set_bus(1'b0, 1'b0, 32'h0);

    // lock holds inst grant while data request arrives
    set_inst(1'b1, 32'h0000_4000);
    eval();
    chk("t3 locked bus_addr c0", bus_addr[0], 32'h0000_4000);
    adv();
    set_data(1'b1, 1'b0, 32'h0000_5000);
    for (int i = 1; i < 4; i++) begin
      eval();
      chk($sformatf("t3 locked bus_addr c%0d", i), bus_addr[0], 32'h0000_4000);
      chk($sformatf("t3 no data grant c%0d", i), 32'(data_addr_ok[0]), 32'd0);
      adv();
    end
    set_bus(1'b1, 1'b0, 32'h0);
    eval();
    chk("t3 inst_addr_ok", 32'(inst_addr_ok[0]), 32'd1);
    adv();
    set_inst(1'b0, 32'h0);
    eval();
    chk("t3 data after unlock", bus_addr[0], 32'h0000_5000);
    chk("t3 data_addr_ok", 32'(data_addr_ok[0]), 32'd1);
    adv();
    set_data(1'b0, 1'b0, 32'h0); set_bus(1'b0, 1'b1, 32'h0000_0031);
    eval(); adv();
    eval(); adv();
    set_bus(1'b0, 1'b0, 32'h0);

    // full blocks a third request; returns in issue order D,I,D
    set_inst(1'b1, 32'h0000_6000); set_data(1'b1, 1'b0, 32'h0000_7000); set_bus(1'b1, 1'b0, 32'h0);
    eval();
    chk("t4 first grant data", 32'(data_addr_ok[0]), 32'd1);
    adv();
    set_data(1'b0, 1'b0, 32'h0);
    eval();
    chk("t4 second grant inst", 32'(inst_addr_ok[0]), 32'd1);
    adv();
    set_inst(1'b0, 32'h0); set_data(1'b1, 1'b1, 32'h0000_7004);
    eval();
    chk("t4 full bus_req", 32'(bus_req[0]), 32'd0);
    chk("t4 full data_addr_ok", 32'(data_addr_ok[0]), 32'd0);
    adv();
    set_bus(1'b1, 1'b1, 32'hcafe_0001);
    eval();
    chk("t4 no pop bypass", 32'(bus_req[0]), 32'd0);
    chk("t4 first return data", 32'(data_data_ok[0]), 32'd1);
    adv();
    set_bus(1'b1, 1'b0, 32'h0);
    eval();
    chk("t4 third grant data", 32'(data_addr_ok[0]), 32'd1);
    chk("t4 third bus_wr", 32'(bus_wr[0]), 32'd1);
    adv();
    set_data(1'b0, 1'b0, 32'h0); set_bus(1'b0, 1'b1, 32'hcafe_0002);
    eval();
    chk("t4 second return inst", 32'(inst_data_ok[0]), 32'd1);
    adv();
    set_bus(1'b0, 1'b1, 32'hcafe_0003);
    eval();
    chk("t4 third return data", 32'(data_data_ok[0]), 32'd1);
    adv();
    set_bus(1'b0, 1'b0, 32'h0);

    // round-robin alternation with push+pop every cycle
    rst = 1'b1;
    eval(); adv();
    rst = 1'b0;
    set_inst(1'b1, 32'h0000_8000); set_data(1'b1, 1'b0, 32'h0000_9000);
    for (int i = 0; i < 8; i++) begin
      set_bus(1'b1, (i > 0), 32'(i));
      eval();
      chk($sformatf("t5 rr inst grant %0d", i), 32'(inst_addr_ok[1]), 32'(i % 2 == 0));
      chk($sformatf("t5 rr data grant %0d", i), 32'(data_addr_ok[1]), 32'(i % 2 == 1));
      if (i > 0) chk($sformatf("t5 rr return %0d", i), 32'(inst_data_ok[1]), 32'((i - 1) % 2 == 0));
      adv();
    end
    set_inst(1'b0, 32'h0); set_data(1'b0, 1'b0, 32'h0); set_bus(1'b0, 1'b1, 32'h0000_0055);
    eval(); adv();
    set_bus(1'b0, 1'b0, 32'h0);

    // reset with two outstanding, then stale responses
    set_inst(1'b1, 32'h0000_a000); set_bus(1'b1, 1'b0, 32'h0);
    eval(); adv();
    eval(); adv();
    set_inst(1'b0, 32'h0); set_bus(1'b0, 1'b1, 32'hdead_0000);
    rst = 1'b1;
    eval();
    chk("t6 in reset inst_data_ok", 32'(inst_data_ok[0]), 32'd0);
    adv();
    rst = 1'b0;
    set_bus(1'b0, 1'b1, 32'hdead_0001);
    eval();
    chk("t6 stale inst_data_ok", 32'(inst_data_ok[0]), 32'd0);
    chk("t6 stale data_data_ok", 32'(data_data_ok[0]), 32'd0);
    adv();
    set_inst(1'b1, 32'h0000_b000); set_bus(1'b1, 1'b0, 32'h0);
    eval();
    chk("t6 regrant inst_addr_ok", 32'(inst_addr_ok[0]), 32'd1);
    adv();
    set_inst(1'b0, 32'h0); set_bus(1'b0, 1'b1, 32'hbeef_0000);
    eval();
    chk("t6 fresh return", 32'(inst_data_ok[0]), 32'd1);
    adv();

    // random traffic, masters hold requests until accepted
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) begin
        if (!(inst_req[k] && !(e_acc[k] && e_win[k] == OWN_INST))) begin
          inst_req[k]   = ($urandom_range(0, 2) != 0);
          inst_wr[k]    = 1'($urandom_range(0, 1));
          inst_size[k]  = 2'($urandom_range(0, 3));
          inst_addr[k]  = $urandom;
          inst_wdata[k] = $urandom;
        end
        if (!(data_req[k] && !(e_acc[k] && e_win[k] == OWN_DATA))) begin
          data_req[k]   = ($urandom_range(0, 2) != 0);
          data_wr[k]    = 1'($urandom_range(0, 1));
          data_size[k]  = 2'($urandom_range(0, 3));
          data_addr[k]  = $urandom;
          data_wdata[k] = $urandom;
        end
        bus_addr_ok[k] = 1'($urandom_range(0, 1));
        bus_data_ok[k] = (qsize(k) > 0) && ($urandom_range(0, 1) == 1);
        bus_rdata[k]   = $urandom;
      end
      eval(); adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
